// File: rtl/noc_traffic_gen.sv
// Multi-channel valid/ready packet source with LFSR, incrementing or fixed data,
// programmable inter-packet gap, packet count and busy/done status.
module noc_traffic_gen #(
    parameter int                WIDTH   = 11,
    parameter int                NUM_CH  = 2,
    parameter logic [15:0]       SEED    = 16'hACE1,
    parameter logic [WIDTH-1:0]  PATTERN = 11'h2AA
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [1:0]              mode,
    input  logic [7:0]              gap,
    input  logic [15:0]             count,
    output logic [NUM_CH-1:0]       out_valid,
    input  logic [NUM_CH-1:0]       out_ready,
    output logic [NUM_CH*WIDTH-1:0] out_data,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP,
        S_DONE
    } state_t;

    logic [1:0]        r_mode;
    logic [7:0]        r_gap;
    logic [15:0]       r_count;
    logic              r_done;
    logic              w_start_ok;
    logic [NUM_CH-1:0] w_active;
    logic [NUM_CH-1:0] w_is_done;

    assign busy       = |w_active;
    assign done       = r_done;
    assign w_start_ok = start && !busy;

    // Configuration is captured only on an accepted start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mode  <= 2'd0;
            r_gap   <= 8'd0;
            r_count <= 16'd0;
        end else if (w_start_ok) begin
            r_mode  <= mode;
            r_gap   <= gap;
            r_count <= count;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_done <= 1'b0;
        end else if (w_start_ok) begin
            r_done <= 1'b0;
        end else if ((&w_is_done) && (r_count != 16'd0)) begin
            r_done <= 1'b1;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        localparam logic [15:0] SEED_X = SEED ^ 16'(c);
        localparam logic [15:0] SEED_C = (SEED_X == 16'd0) ? 16'd1 : SEED_X;

        state_t           r_state;
        state_t           w_state_nxt;
        logic [15:0]      r_lfsr;
        logic [15:0]      w_lfsr_nxt;
        logic [15:0]      r_sent;
        logic [15:0]      w_sent_inc;
        logic [WIDTH-1:0] r_seq;
        logic [WIDTH-1:0] w_value;
        logic [7:0]       r_gap_cnt;
        logic             w_hs;

        assign w_hs       = (r_state == S_SEND) && out_ready[c];
        assign w_sent_inc = r_sent + 16'd1;
        assign w_lfsr_nxt = r_lfsr[0] ? ((r_lfsr >> 1) ^ 16'hB400) : (r_lfsr >> 1);

        always_comb begin
            w_state_nxt = r_state;
            if (w_start_ok) begin
                w_state_nxt = S_SEND;
            end else begin
                case (r_state)
                    S_SEND: begin
                        if (w_hs) begin
                            if ((r_count != 16'd0) && (w_sent_inc == r_count)) begin
                                w_state_nxt = S_DONE;
                            end else if (r_gap != 8'd0) begin
                                w_state_nxt = S_GAP;
                            end
                        end
                    end
                    S_GAP: begin
                        // Counter is loaded with gap on entry, so leaving at 1 gives exactly gap idle cycles.
                        if (r_gap_cnt <= 8'd1) begin
                            w_state_nxt = S_SEND;
                        end
                    end
                    default: w_state_nxt = r_state;
                endcase
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_state   <= S_IDLE;
                r_lfsr    <= SEED_C;
                r_sent    <= 16'd0;
                r_seq     <= '0;
                r_gap_cnt <= 8'd0;
            end else begin
                r_state <= w_state_nxt;
                if (w_start_ok) begin
                    r_sent <= 16'd0;
                    r_seq  <= '0;
                end else if (w_hs) begin
                    r_sent    <= w_sent_inc;
                    r_seq     <= r_seq + 1'b1;
                    r_lfsr    <= w_lfsr_nxt;
                    r_gap_cnt <= r_gap;
                end else if (r_state == S_GAP) begin
                    r_gap_cnt <= r_gap_cnt - 8'd1;
                end
            end
        end

        always_comb begin
            case (r_mode)
                2'd1:    w_value = r_seq;
                2'd2:    w_value = PATTERN;
                default: w_value = r_lfsr[WIDTH-1:0];
            endcase
        end

        // Data is gated by valid so the bus reads zero whenever no packet is offered.
        assign out_valid[c]                 = (r_state == S_SEND);
        assign out_data[c*WIDTH +: WIDTH]   = out_valid[c] ? w_value : '0;
        assign w_active[c]                  = (r_state == S_SEND) || (r_state == S_GAP);
        assign w_is_done[c]                 = (r_state == S_DONE);
    end

endmodule
